// File: rtl/lc_state_matcher.sv
// lc_state_matcher: walks the life-cycle hash ROM one entry at a time and
// compares each entry against a latched candidate hash. The lowest matching
// index is reported as the decoded state; duplicate matches and ROM read
// timeouts are flagged. Every output comes straight from a flop.
module lc_state_matcher #(
  parameter int WIDTH   = 256,
  parameter int LENGTH  = 6,
  parameter int TIMEOUT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          cand_hash,
  output logic                      mem_rd_en,
  output logic [$clog2(LENGTH)-1:0] mem_addr,
  input  logic [WIDTH-1:0]          mem_rdData,
  input  logic                      mem_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      match,
  output logic [$clog2(LENGTH)-1:0] match_idx,
  output logic                      multi_match,
  output logic                      timeout_err
);

  localparam int IW = $clog2(LENGTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [WIDTH-1:0]  cand_q, cand_d;
  logic              match_q, match_d;
  logic [IW-1:0]     match_idx_q, match_idx_d;
  logic              multi_q, multi_d;
  logic              tmo_q, tmo_d;
  logic              rd_en_q, rd_en_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Next-state and result update; strobes are decoded from the next state so
  // they appear registered in the same cycle as the state they belong to.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    cand_d      = cand_q;
    match_d     = match_q;
    match_idx_d = match_idx_q;
    multi_d     = multi_q;
    tmo_d       = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cand_d      = cand_hash;
          idx_d       = '0;
          match_d     = 1'b0;
          match_idx_d = '0;
          multi_d     = 1'b0;
          tmo_d       = 1'b0;
          // The ROM reads back zero when idle, so an all-zero candidate would
          // match spuriously; finish without touching the ROM.
          if (cand_hash == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mem_valid) begin
          if (mem_rdData == cand_q) begin
            if (match_q) begin
              multi_d = 1'b1;
            end else begin
              match_d     = 1'b1;
              match_idx_d = idx_q;
            end
          end else begin
            match_d = match_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_ISSUE;
          end
        end else if (timer_q == TMR_MAX) begin
          // Partial match results are deliberately kept.
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_en_d = (state_d == S_ISSUE);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State, scan context and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      cand_q      <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      multi_q     <= 1'b0;
      tmo_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      cand_q      <= cand_d;
      match_q     <= match_d;
      match_idx_q <= match_idx_d;
      multi_q     <= multi_d;
      tmo_q       <= tmo_d;
      rd_en_q     <= rd_en_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match       = match_q;
  assign match_idx   = match_idx_q;
  assign multi_match = multi_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_lc_state_matcher.sv
// Testbench for lc_state_matcher: 1-cycle-latency ROM model, scenario tasks
// and a randomized loop checked against a list-based reference model.
module tb_lc_state_matcher;

  localparam int WIDTH   = 256;
  localparam int LENGTH  = 6;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] cand_hash = '0;
  logic             mem_rd_en;
  logic [2:0]       mem_addr;
  logic [WIDTH-1:0] mem_rdData = '0;
  logic             mem_valid = 1'b0;
  logic             busy, done, match, multi_match, timeout_err;
  logic [2:0]       match_idx;

  logic [WIDTH-1:0] rom [LENGTH];
  int               supp_addr = -1;

  int checks   = 0;
  int failures = 0;

  lc_state_matcher #(.WIDTH(WIDTH), .LENGTH(LENGTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .cand_hash(cand_hash),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdData(mem_rdData),
    .mem_valid(mem_valid), .busy(busy), .done(done), .match(match),
    .match_idx(match_idx), .multi_match(multi_match), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ROM model: one cycle of latency, zero data when not enabled, optional
  // suppression of valid for one address.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdData <= (int'(mem_addr) < LENGTH) ? rom[mem_addr] : '0;
      mem_valid  <= (int'(mem_addr) != supp_addr);
    end else begin
      mem_rdData <= '0;
      mem_valid  <= 1'b0;
    end
  end

  function automatic logic [WIDTH-1:0] rand_hash();
    logic [WIDTH-1:0] h;
    for (int w = 0; w < WIDTH / 32; w++) h[w*32 +: 32] = $urandom;
    return h;
  endfunction

  // Reference: scan the list in order, stop at a suppressed address.
  task automatic model(input logic [WIDTH-1:0] c, input int supp,
                       output bit e_match, output int e_idx, output bit e_multi,
                       output bit e_tmo, output int e_reads, output int e_done);
    e_match = 0; e_idx = 0; e_multi = 0; e_tmo = 0; e_reads = 0;
    e_done = 2 * LENGTH + 1;
    if (c == '0) begin
      e_done = 1;
      return;
    end
    for (int i = 0; i < LENGTH; i++) begin
      e_reads = i + 1;
      if (i == supp) begin
        e_tmo  = 1;
        e_done = 2 * i + 1 + TIMEOUT + 1;
        return;
      end
      if (rom[i] == c) begin
        if (e_match) e_multi = 1;
        else begin e_match = 1; e_idx = i; end
      end
    end
  endtask

  // Runs one scan and checks timing, ROM access pattern and results.
  // restart_cyc >= 0 pulses start with another candidate at that cycle;
  // poke_done pulses start again during the done cycle.
  task automatic run_scan(input string name, input logic [WIDTH-1:0] c,
                          input int supp, input int restart_cyc, input bit poke_done);
    bit e_match, e_multi, e_tmo;
    int e_idx, e_reads, e_done;
    int cyc, reads, got_done;
    bit prev_rd;
    bit ok_addr, ok_pulse, ok_busy;
    model(c, supp, e_match, e_idx, e_multi, e_tmo, e_reads, e_done);
    supp_addr = supp;
    @(negedge clk);
    start = 1'b1; cand_hash = c;
    @(posedge clk); #1;
    start = 1'b0; cand_hash = rand_hash();
    cyc = 1; reads = 0; got_done = 0; prev_rd = 0;
    ok_addr = 1; ok_pulse = 1; ok_busy = 1;
    while (cyc < 60) begin
      if (mem_rd_en) begin
        if (prev_rd) ok_pulse = 0;
        if (int'(mem_addr) != reads) ok_addr = 0;
        reads++;
      end
      prev_rd = mem_rd_en;
      if (busy !== 1'b1) ok_busy = 0;
      if (done === 1'b1) begin got_done = cyc; break; end
      if (cyc == restart_cyc) begin start = 1'b1; cand_hash = rom[2]; end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    checks++;
    if (got_done != e_done) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, got_done, e_done);
    end
    checks++;
    if (reads != e_reads || !ok_addr || !ok_pulse) begin
      failures++;
      $display("FAIL %s rom_reads: got %0d (addr_ok=%0d single=%0d) expected %0d", name, reads, ok_addr, ok_pulse, e_reads);
    end
    checks++;
    if (!ok_busy) begin
      failures++;
      $display("FAIL %s busy: got 0 during scan expected 1", name);
    end
    checks++;
    if (match !== e_match || int'(match_idx) != e_idx || multi_match !== e_multi || timeout_err !== e_tmo) begin
      failures++;
      $display("FAIL %s result: got m=%b idx=%0d mm=%b to=%b expected m=%0d idx=%0d mm=%0d to=%0d",
               name, match, match_idx, multi_match, timeout_err, e_match, e_idx, e_multi, e_tmo);
    end
    if (poke_done) begin start = 1'b1; cand_hash = rom[3]; end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: got done=%b busy=%b rd=%b expected 0 0 0", name, done, busy, mem_rd_en);
    end
    checks++;
    if (match !== e_match || int'(match_idx) != e_idx || multi_match !== e_multi || timeout_err !== e_tmo) begin
      failures++;
      $display("FAIL %s result_hold: got m=%b idx=%0d mm=%b to=%b expected m=%0d idx=%0d mm=%0d to=%0d",
               name, match, match_idx, multi_match, timeout_err, e_match, e_idx, e_multi, e_tmo);
    end
    supp_addr = -1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({mem_rd_en, busy, done, match, multi_match, timeout_err} !== 6'b0 ||
        mem_addr !== 3'd0 || match_idx !== 3'd0) begin
      failures++;
      $display("FAIL %s outputs: got rd=%b addr=%0d busy=%b done=%b m=%b idx=%0d mm=%b to=%b expected all 0",
               name, mem_rd_en, mem_addr, busy, done, match, match_idx, multi_match, timeout_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    check_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset_released");
  endtask

  task automatic test_single_match();
    run_scan("match_rom2", rom[2], -1, -1, 0);
  endtask

  task automatic test_duplicate();
    run_scan("dup_rom0", rom[0], -1, -1, 0);
  endtask

  task automatic test_no_match();
    logic [WIDTH-1:0] one = 256'h1;
    run_scan("no_match", one, -1, -1, 0);
    run_scan("zero_cand", '0, -1, -1, 0);
  endtask

  task automatic test_timeout();
    run_scan("timeout_addr3", rom[5], 3, -1, 0);
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    bit seen;
    bit saw_done;
    @(negedge clk);
    start = 1'b1; cand_hash = rom[5];
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (cyc = 0; cyc < 30 && !seen; cyc++) begin
      if (mem_rd_en && mem_addr == 3'd2) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_mid reach_addr2: got no read of addr 2 expected one");
    end
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_async");
    saw_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL reset_mid no_done: got done pulse expected none");
    end
    run_scan("after_reset_rom4", rom[4], -1, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_scan("restart_ignored", rom[3], -1, 5, 1);
    run_scan("b2b_rom5", rom[5], -1, -1, 0);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] c;
    int sel, supp;
    for (int n = 0; n < 25; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < LENGTH) c = rom[sel];
      else if (sel == 9) c = '0;
      else c = rand_hash();
      supp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LENGTH - 1) : -1;
      run_scan($sformatf("rand%0d", n), c, supp, $urandom_range(0, 1) ? $urandom_range(1, 10) : -1,
               1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rom[0] = 256'h33a344a3_5c1d7e90_a4b3c2d1_0e9f8a7b_6c5d4e3f_21130405_f6e7d8c9_ea56a24a;
    rom[1] = rom[0];
    rom[2] = 256'h988b6a57_13579bdf_2468ace0_fedcba98_76543210_0badf00d_deadbeef_b8a93348;
    rom[3] = 256'h4893565d_a1b2c3d4_e5f60718_293a4b5c_6d7e8f90_11223344_55667788_f988284e;
    rom[4] = 256'hcabc36e4_99aabbcc_ddeeff00_12345678_9abcdef0_0fedcba9_87654321_b3870e03;
    rom[5] = 256'hc3e0fed6_c001d00d_feedface_cafebabe_8badf00d_1337c0de_abad1dea_4fd801e5;
    test_reset();
    test_single_match();
    test_duplicate();
    test_no_match();
    test_timeout();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
